// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the memory/write-back stage.
package cpu_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 16;
  localparam logic [REG_W-1:0] R16_ADDR = 5'b10000;

  typedef enum logic [1:0] {
    MWB_IDLE   = 2'd0,
    MWB_WAIT   = 2'd1,
    MWB_HALTED = 2'd2
  } mwb_state_t;

  typedef struct packed {
    logic              we0;
    logic              we1;
    logic [REG_W-1:0]  addr0;
    logic [REG_W-1:0]  addr1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
  } mwb_reg_t;

endpackage

// File: rtl/memory_writeback_if.sv
// Ready-handshaked data-memory port between the MWB stage (master) and data memory (slave).
interface memory_writeback_if #(parameter int ADDR_W = 16);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [15:0]       dmem_wdata;
  logic [15:0]       dmem_rdata;
  logic              dmem_rdy;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  input  dmem_rdata, dmem_rdy);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  output dmem_rdata, dmem_rdy);
endinterface

// File: rtl/memory_writeback_dmem_access_fsm.sv
// Data-memory access FSM: drives the dmem request, the upstream stall and the sticky halt state.
module dmem_access_fsm
  import cpu_pkg::*;
#(parameter int ADDR_W = 16) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              DEX_mem_we,
  input  logic              DEX_mem_re,
  input  logic              DEX_halt,
  input  logic [ADDR_W-1:0] DEX_mem_read_addr,
  input  logic [15:0]       DEX_mem_write_data,
  memory_writeback_if.master dmem,
  output logic              mem_stall,
  output logic              halted
);

  localparam logic [1:0] IDLE   = MWB_IDLE;
  localparam logic [1:0] WAIT   = MWB_WAIT;
  localparam logic [1:0] HALTED = MWB_HALTED;

  logic [1:0] state_q, state_d;
  logic       access;

  assign halted = (state_q == HALTED);
  assign access = (DEX_mem_re | DEX_mem_we) & ~halted;

  // rst_n gating keeps the request low for the whole reset, not just after the next edge
  assign dmem.dmem_req   = access & rst_n;
  assign dmem.dmem_we    = DEX_mem_we;
  assign dmem.dmem_addr  = DEX_mem_read_addr;
  assign dmem.dmem_wdata = DEX_mem_write_data;
  assign mem_stall       = access & ~dmem.dmem_rdy & rst_n;

  // WAIT and IDLE share outputs; DEX fields are frozen by mem_stall while waiting
  always_comb begin
    state_d = IDLE;
    if (halted)
      state_d = HALTED;
    else if (mem_stall)
      state_d = WAIT;
    else if (DEX_halt)
      state_d = HALTED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

endmodule

// File: rtl/memory_writeback.sv
// Memory/write-back stage: write-back muxes, MWB register and optional stall counter.
// Optional feature: define MWB_PERF_CNT_EN to build the saturating stall_cycles counter.
module memory_writeback
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              DEX_alu_to_reg,
  input  logic              DEX_pcr_to_reg,
  input  logic              DEX_mem_to_reg,
  input  logic              DEX_imm_to_reg,
  input  logic              DEX_reg_we_dst_0,
  input  logic              DEX_reg_we_dst_1,
  input  logic              DEX_mem_we,
  input  logic              DEX_mem_re,
  input  logic              DEX_halt,
  input  logic [REG_W-1:0]  DEX_dst_addr_0,
  input  logic [REG_W-1:0]  DEX_dst_addr_1,
  input  logic [DATA_W-1:0] DEX_alu_result,
  input  logic [DATA_W-1:0] DEX_PC_return,
  input  logic [DATA_W-1:0] DEX_load_immd,
  input  logic [DATA_W-1:0] DEX_reg_data_0,
  input  logic [DATA_W-1:0] DEX_reg_data_1,
  input  logic [ADDR_W-1:0] DEX_mem_read_addr,
  input  logic [DATA_W-1:0] DEX_mem_write_data,
  memory_writeback_if.master dmem,
  output logic              mem_stall,
  output logic              we_CPU_0,
  output logic              we_CPU_1,
  output logic [REG_W-1:0]  wrt_addr_0,
  output logic [REG_W-1:0]  wrt_addr_1,
  output logic [DATA_W-1:0] wrt_data_0,
  output logic [DATA_W-1:0] wrt_data_1,
  output logic              cpu_halted,
  output logic [CNT_W-1:0]  stall_cycles
);

  mwb_reg_t mwb_q, mwb_d;
  logic     conflict;

  dmem_access_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk                (clk),
    .rst_n              (rst_n),
    .DEX_mem_we         (DEX_mem_we),
    .DEX_mem_re         (DEX_mem_re),
    .DEX_halt           (DEX_halt),
    .DEX_mem_read_addr  (DEX_mem_read_addr),
    .DEX_mem_write_data (DEX_mem_write_data),
    .dmem               (dmem),
    .mem_stall          (mem_stall),
    .halted             (cpu_halted)
  );

  // Port 1 wins a same-register dual write
  assign conflict = DEX_reg_we_dst_0 & DEX_reg_we_dst_1 & (DEX_dst_addr_0 == DEX_dst_addr_1);

  always_comb begin
    mwb_d = mwb_q;
    if (cpu_halted || mem_stall) begin
      mwb_d.we0 = 1'b0;
      mwb_d.we1 = 1'b0;
    end else begin
      mwb_d.we0   = DEX_reg_we_dst_0 & ~conflict;
      mwb_d.we1   = DEX_reg_we_dst_1;
      mwb_d.addr0 = DEX_dst_addr_0;
      mwb_d.addr1 = DEX_dst_addr_1;
      if (DEX_mem_to_reg)      mwb_d.data0 = dmem.dmem_rdata;
      else if (DEX_imm_to_reg) mwb_d.data0 = DEX_load_immd;
      else if (DEX_alu_to_reg) mwb_d.data0 = DEX_alu_result;
      else                     mwb_d.data0 = DEX_reg_data_1;
      mwb_d.data1 = DEX_pcr_to_reg ? DEX_PC_return : DEX_reg_data_0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mwb_q <= '0;
    else        mwb_q <= mwb_d;
  end

  assign we_CPU_0   = mwb_q.we0;
  assign we_CPU_1   = mwb_q.we1;
  assign wrt_addr_0 = mwb_q.addr0;
  assign wrt_addr_1 = mwb_q.addr1;
  assign wrt_data_0 = mwb_q.data0;
  assign wrt_data_1 = mwb_q.data1;

`ifdef MWB_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (mem_stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: doc/memory_writeback.md
# memory_writeback

Final CPU pipeline stage, directly downstream of decode/execute. Consumes the DEX pipeline register, performs the data-memory access for LDR/ST over a ready-handshaked data-memory port, and selects the write-back data. Drives the register file's two CPU write ports (`we_CPU_0/1`, `wrt_addr_0/1`, `wrt_data_0/1`) from its own MWB pipeline register. Produces `mem_stall`, which freezes all upstream stages, and a sticky `cpu_halted`.

## Interface
Parameters:
- `ADDR_W`, default 16: data-memory address width.
- `CNT_W`, default 16: stall-counter width (used only with `MWB_PERF_CNT_EN`).

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `DEX_alu_to_reg`, `DEX_pcr_to_reg`, `DEX_mem_to_reg`, `DEX_imm_to_reg` in 1 each: write-back source selects.
- `DEX_reg_we_dst_0`, `DEX_reg_we_dst_1` in 1 each: write enables.
- `DEX_mem_we`, `DEX_mem_re`, `DEX_halt` in 1 each: store, load, halt.
- `DEX_dst_addr_0`, `DEX_dst_addr_1` in 5 each: destination registers.
- `DEX_alu_result`, `DEX_PC_return`, `DEX_load_immd`, `DEX_reg_data_0`, `DEX_reg_data_1` in 16 each: candidate write data.
- `DEX_mem_read_addr` in ADDR_W: load/store address. `DEX_mem_write_data` in 16: store data.
- `dmem_req` out 1: access request. `dmem_we` out 1: 1 = store.
- `dmem_addr` out ADDR_W. `dmem_wdata` out 16.
- `dmem_rdata` in 16: load data. `dmem_rdy` in 1: access complete this cycle.
- `mem_stall` out 1: upstream hold.
- `we_CPU_0`, `we_CPU_1` out 1 each.
- `wrt_addr_0`, `wrt_addr_1` out 5 each. `wrt_data_0`, `wrt_data_1` out 16 each.
- `cpu_halted` out 1: sticky halt.
- `stall_cycles` out CNT_W: memory-stall cycle count.

## Operation
- FSM states: `IDLE`, `WAIT`, `HALTED`. `access = (DEX_mem_re | DEX_mem_we) & state != HALTED`.
- **IDLE**
  - `dmem_req = access`, combinational from DEX.
  - `dmem_we = DEX_mem_we`, `dmem_addr = DEX_mem_read_addr`, `dmem_wdata = DEX_mem_write_data`.
  - `access & ~dmem_rdy` → `WAIT`.
  - `access & dmem_rdy` → zero-wait completion; stay in `IDLE`.
- **WAIT**
  - `dmem_req` is held high with DEX-sourced fields, which are stable because upstream is frozen.
  - `dmem_rdy` → `IDLE`.
- `mem_stall = access & ~dmem_rdy`, combinational. It must be ORed into every upstream pipeline-register hold.
- Port-0 data priority:
  1. `DEX_mem_to_reg` → `dmem_rdata`, sampled in the `dmem_rdy` cycle.
  2. `DEX_imm_to_reg` → `DEX_load_immd`.
  3. `DEX_alu_to_reg` → `DEX_alu_result`.
  4. Otherwise → `DEX_reg_data_1` (SWAP).
- Port-1 data: `DEX_pcr_to_reg ? DEX_PC_return : DEX_reg_data_0`.
- MWB register update:
  - While `mem_stall`: `we_CPU_0/1` load 0 (bubble). Addresses and data hold.
  - Otherwise: all fields load from DEX.
- Same-address conflict: both enables set with `DEX_dst_addr_0 == DEX_dst_addr_1` → `we_CPU_0` forced 0; port 1 wins.
- Halt:
  - `DEX_halt` with no stall → `HALTED` and `cpu_halted = 1` next cycle.
  - Writes from the halt-carrying instruction itself still complete.
  - In `HALTED`: `dmem_req`, `we_CPU_0/1`, `mem_stall` stay 0 until reset.
- A store never asserts `we_CPU_*` unless its DEX enables say so.

## Timing
- Reset values: state `IDLE`; `we_CPU_0/1`, `cpu_halted`, `stall_cycles` = 0; `wrt_addr_*`, `wrt_data_*` = 0. `dmem_req` and `mem_stall` are 0 while `rst_n` is low.
- Non-memory instruction: DEX value at edge N appears on `wrt_*` after edge N+1 (1-cycle latency).
- Load with k wait cycles (`dmem_rdy` low k cycles): `mem_stall` high k cycles; `wrt_data_0 = dmem_rdata` one edge after the `rdy` cycle.
- Reset mid-`WAIT`: `dmem_req` drops immediately; the access is abandoned. The memory side must tolerate request withdrawal.
- `dmem_rdy` while `dmem_req = 0`: ignored.

## Configuration
- `MWB_PERF_CNT_EN` defined:
  - `stall_cycles` increments every cycle `mem_stall = 1`.
  - Saturates at all-ones.
  - Cleared only by reset.
- Undefined: `stall_cycles` tied to 0 and no counter flops are built.

## Structure
- Shared package `cpu_pkg` holds:
  - The FSM state enum `mwb_state_t`.
  - `REG_W = 5`, `DATA_W = 16`.
  - `R16_ADDR = 5'b10000`.
- One sub-module, `dmem_access_fsm`, owns the FSM, the `dmem_*` outputs and `mem_stall`. The top level holds the data muxes, MWB register and counter.

## Test plan
- ALU write: `DEX_alu_to_reg=1`, `we_dst_0=1`, `dst_addr_0=3`, `alu_result=16'h1234` → next cycle `we_CPU_0=1`, `wrt_addr_0=3`, `wrt_data_0=16'h1234`, `mem_stall` never high.
- Load, 3 wait cycles: `addr=16'h0040`, `dmem_rdy` low 3 cycles then high with `rdata=16'hBEEF` → `mem_stall` high exactly 3 cycles, `we_CPU_0` low during stall, then one write of `16'hBEEF`. With the counter macro, `stall_cycles=3`.
- Zero-wait store: `mem_we=1`, `rdy=1` same cycle, `wdata=16'h00A5` → `dmem_req=1`, `dmem_we=1` for 1 cycle, no stall, `we_CPU_*=0`.
- Jump/SWAP conflict: `we_dst_0=1` and `we_dst_1=1`, both addresses 16, `pcr_to_reg=1`, `PC_return=16'h0021` → only `we_CPU_1=1`, `wrt_data_1=16'h0021`.
- Halt then load: halt cycle then `mem_re` → `cpu_halted=1` from next cycle, `dmem_req` stays 0, no writes.
- Reset mid-`WAIT`: `rst_n` low during stalled load → `dmem_req` and `mem_stall` drop immediately. After release, all outputs are at reset values.
